// File: rtl/sm3_round_ctrl.sv
// sm3_round_ctrl: sequences the 64 SM3 compression rounds for one block and
// produces V(i+1) = ABCDEFGH ^ V(i) with a valid/ready handshake.
`default_nettype none

module sm3_ff_j (
  input  logic [5:0]  i_j,
  input  logic [31:0] i_x,
  input  logic [31:0] i_y,
  input  logic [31:0] i_z,
  output logic [31:0] o_ff
);
  assign o_ff = (i_j < 6'd16) ? (i_x ^ i_y ^ i_z)
                              : ((i_x & i_y) | (i_x & i_z) | (i_y & i_z));
endmodule

module sm3_round_ctrl #(
  parameter logic [31:0] T_LOW  = 32'h79cc4519,
  parameter logic [31:0] T_HIGH = 32'h7a879d8a
) (
  input  logic         input_clk,
  input  logic         input_rst_n,
  input  logic         input_start_valid,
  output logic         output_start_ready,
  input  logic [0:255] input_V,
  output logic [0:5]   output_round_index,
  output logic         output_round_active,
  input  logic [0:31]  input_W,
  input  logic [0:31]  input_W1,
  output logic [0:255] output_hash,
  output logic         output_hash_valid,
  input  logic         input_hash_ready,
  output logic         output_busy
);

  localparam int NUM_ROUNDS = 64;
  localparam logic [5:0] LAST_ROUND = 6'(NUM_ROUNDS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_FINAL = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t       r_state;
  logic [31:0]  r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h;
  logic [0:255] r_v;
  logic [0:255] r_hash;
  logic [5:0]   r_j;
  logic         r_hash_valid;
  logic         r_round_active;
  logic         r_busy;
  logic         r_start_ready;

  function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] n);
    logic [63:0] w_tmp;
    w_tmp = {x, x} << n;
    return w_tmp[63:32];
  endfunction

  logic [31:0] w_t, w_a12, w_ss1, w_ss2, w_ff, w_gg, w_tt1, w_tt2, w_p0;
  logic [31:0] w_w, w_w1;

  assign w_w   = input_W;
  assign w_w1  = input_W1;
  assign w_t   = (r_j < 6'd16) ? T_LOW : T_HIGH;
  assign w_a12 = rotl(r_a, 5'd12);
  assign w_ss1 = rotl(w_a12 + r_e + rotl(w_t, r_j[4:0]), 5'd7);
  assign w_ss2 = w_ss1 ^ w_a12;
  assign w_gg  = (r_j < 6'd16) ? (r_e ^ r_f ^ r_g) : ((r_e & r_f) | (~r_e & r_g));
  assign w_tt1 = w_ff + r_d + w_ss2 + w_w1;
  assign w_tt2 = w_gg + r_h + w_ss1 + w_w;
  assign w_p0  = w_tt2 ^ rotl(w_tt2, 5'd9) ^ rotl(w_tt2, 5'd17);

  sm3_ff_j u_ff (
    .i_j  (r_j),
    .i_x  (r_a),
    .i_y  (r_b),
    .i_z  (r_c),
    .o_ff (w_ff)
  );

  always_ff @(posedge input_clk or negedge input_rst_n) begin
    if (!input_rst_n) begin
      r_state        <= S_IDLE;
      r_a            <= '0;
      r_b            <= '0;
      r_c            <= '0;
      r_d            <= '0;
      r_e            <= '0;
      r_f            <= '0;
      r_g            <= '0;
      r_h            <= '0;
      r_v            <= '0;
      r_hash         <= '0;
      r_j            <= '0;
      r_hash_valid   <= 1'b0;
      r_round_active <= 1'b0;
      r_busy         <= 1'b0;
      r_start_ready  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // Ready only rises on the first edge after reset release.
          if (r_start_ready && input_start_valid) begin
            {r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h} <= input_V;
            r_v            <= input_V;
            r_j            <= '0;
            r_state        <= S_ROUND;
            r_start_ready  <= 1'b0;
            r_busy         <= 1'b1;
            r_round_active <= 1'b1;
          end else begin
            r_start_ready  <= 1'b1;
          end
        end
        S_ROUND: begin
          r_d <= r_c;
          r_c <= rotl(r_b, 5'd9);
          r_b <= r_a;
          r_a <= w_tt1;
          r_h <= r_g;
          r_g <= rotl(r_f, 5'd19);
          r_f <= r_e;
          r_e <= w_p0;
          if (r_j == LAST_ROUND) begin
            r_state        <= S_FINAL;
            r_round_active <= 1'b0;
          end else begin
            r_j <= r_j + 6'd1;
          end
        end
        S_FINAL: begin
          r_hash       <= {r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h} ^ r_v;
          r_hash_valid <= 1'b1;
          r_state      <= S_DONE;
        end
        S_DONE: begin
          if (input_hash_ready) begin
            r_hash_valid  <= 1'b0;
            r_state       <= S_IDLE;
            r_busy        <= 1'b0;
            r_start_ready <= 1'b1;
          end
        end
        default: begin
          r_state        <= S_IDLE;
          r_busy         <= 1'b0;
          r_round_active <= 1'b0;
          r_hash_valid   <= 1'b0;
          r_start_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign output_start_ready  = r_start_ready;
  assign output_round_index  = r_j;
  assign output_round_active = r_round_active;
  assign output_hash         = r_hash;
  assign output_hash_valid   = r_hash_valid;
  assign output_busy         = r_busy;

endmodule

`default_nettype wire

// File: doc/sm3_round_ctrl.md
Name: sm3_round_ctrl

Overview:
Sequences one SM3 compression (CF) of a 512-bit block over 64 rounds. Holds the A..H working registers and drives the round index to an external message-expansion buffer, which returns W_j/W'_j. Reuses the existing FF boolean block for FF_j and computes GG_j locally. Sits between the padding/expansion front end and the multi-block hash chaining logic.

Parameters:
T_LOW, 32'h79cc4519, T_j constant for j = 0..15
T_HIGH, 32'h7a879d8a, T_j constant for j = 16..63
NUM_ROUNDS, 64, number of rounds; fixed by SM3, not for override

Ports:
input_clk  in  1  clock, rising edge
input_rst_n  in  1  reset, asynchronous assert, active-low
input_start_valid  in  1  request to compress one block
output_start_ready  out  1  high only in IDLE
input_V  in  [0:255]  chaining value V(i); [0:31]=A ... [224:255]=H; bit 0 = MSB
output_round_index  out  [0:5]  current j, to the expansion buffer
output_round_active  out  1  high in ROUND; W/W1 must be valid combinationally for output_round_index
input_W  in  [0:31]  W_j
input_W1  in  [0:31]  W'_j
output_hash  out  [0:255]  V(i+1) = ABCDEFGH ^ V(i), same word order as input_V
output_hash_valid  out  1  output_hash valid
input_hash_ready  in  1  consumer accepts output_hash
output_busy  out  1  state != IDLE

Behaviour:
- Reset (input_rst_n low, async): state=IDLE; A..H, saved V, output_hash = 0; j=0; output_hash_valid=0; output_round_active=0; output_busy=0; output_start_ready=1 after reset release.
- States: IDLE, ROUND, FINAL, DONE.
- IDLE: start_ready=1. On edge with start_valid=1: A..H <- input_V; save V <- input_V; j <- 0; go to ROUND. input_V is ignored after capture.
- ROUND: round_active=1; round_index=j. Each edge performs one round (arithmetic mod 2^32, <<< is rotate-left):
  SS1 = ((A<<<12) + E + (T_j <<< (j mod 32))) <<< 7
  SS2 = SS1 ^ (A<<<12)
  TT1 = FF_j(A,B,C) + D + SS2 + W1
  TT2 = GG_j(E,F,G) + H + SS1 + W
  D<=C; C<=B<<<9; B<=A; A<=TT1; H<=G; G<=F<<<19; F<=E; E<=P0(TT2), where P0(x) = x^(x<<<9)^(x<<<17).
  T_j = T_LOW for j<16, else T_HIGH.
  FF_j comes from the existing FF block, driven with j.
  GG_j = X^Y^Z for j<16; else (X&Y)|(~X&Z).
  j increments each edge. The edge that performs j=63 goes to FINAL; j is not incremented past 63 (no wrap to 0 inside a block).
- FINAL: one cycle. Edge: output_hash <- {A..H} ^ saved V; output_hash_valid <- 1; go to DONE.
- DONE: output_hash and valid held stable until an edge with input_hash_ready=1. On that edge: valid <- 0; go to IDLE. output_hash retains its value.
- Latency: start accepted at edge E0; rounds 0..63 on edges E1..E64; output_hash_valid high after edge E65. Next start accepted no earlier than the edge after the hash handshake.
- start_valid outside IDLE: ignored (start_ready=0); no request is queued.
- hash_ready outside DONE: ignored.
- Reset mid-ROUND/FINAL/DONE: aborts immediately; no hash is produced; state returns to IDLE.
- W/W1 are sampled only on ROUND edges. X on W/W1 outside ROUND must not propagate.

Test Plan:
1. Reset behaviour: assert rst_n low mid-cycle -> all outputs zero asynchronously; after release, start_ready=1 and busy=0.
2. "abc" vector: V = IV 7380166f 4914b2b9 172442d7 da8a0600 a96f30bc 163138aa e38dee4d b0fb0e4e; expansion model fed with block 61626380 00000000 x14 00000018 -> output_hash = 66c7f0f4 62eeedd9 d1f2d46b dc10e4e2 4167c487 5cf2f7a2 297da02b 8f4ba8e0; valid rises exactly 65 edges after the start edge.
3. Round index trace: check round_index sequences 0..63, with round_active high for exactly 64 cycles. After round j=0, compare A and E against the golden model (checks T_LOW with rotation 0); after j=16, compare again (checks T_HIGH, FF/GG switch).
4. Backpressure: hold hash_ready=0 for 20 cycles -> output_hash and valid stable, start_ready=0. A start_valid pulse during DONE is ignored. Raise hash_ready -> idle next cycle; a following start computes a second block (chained V) that matches the model.
5. Abort: assert reset at round j=30, release, then run the "abc" vector -> correct hash, with no residue from the aborted run.
6. Back-to-back: hold start_valid=1 continuously with hash_ready=1 -> a new block starts exactly 1 cycle after each hash handshake, and every result matches the model.
